// File: rtl/dly_line_tap.sv
// dly_line_tap: RAM-based circular-buffer delay line with one read tap.
// Ports: clk, rst (async, active-high), clr, en, dly, din -> dout, dout_valid.
// Optional macro DLY_LINE_FILL_EN adds fill_lvl (fill count) and dly_eff (delay).
module dly_line_tap #(
  parameter int SIG_WIDTH = 16,
  parameter int DEPTH     = 512,
  parameter int DLY_W     = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DLY_W-1:0]     dly,
  input  logic [SIG_WIDTH-1:0] din,
  output logic [SIG_WIDTH-1:0] dout,
  output logic                 dout_valid
`ifdef DLY_LINE_FILL_EN
  ,
  output logic [DLY_W-1:0]     fill_lvl,
  output logic [DLY_W-1:0]     dly_eff
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW = DLY_W + 1;

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  logic [SIG_WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]        r_wr_ptr;
  logic [DLY_W-1:0]     r_fill;
  logic [DLY_W-1:0]     r_dly;
  logic [SIG_WIDTH-1:0] r_dout;
  state_t               r_state;
  state_t               w_state_nxt;

  logic [DLY_W-1:0]     w_dly_c;
  logic                 w_chg;
  logic [AW-1:0]        w_ptr_nxt;
  logic [DLY_W-1:0]     w_fill_nxt;
  logic [XW-1:0]        w_sum;
  logic [AW-1:0]        w_ra;
  logic                 w_primed;

  always_comb begin
    w_dly_c = dly;
    if (dly == '0)
      w_dly_c = DLY_W'(1);
    else if (dly > DLY_W'(DEPTH))
      w_dly_c = DLY_W'(DEPTH);
  end

  assign w_chg = (w_dly_c != r_dly) && !clr;

  assign w_ptr_nxt = (r_wr_ptr == AW'(DEPTH-1)) ?
                     '0 : r_wr_ptr + AW'(1);

  assign w_fill_nxt = (r_fill == DLY_W'(DEPTH)) ?
                      r_fill : r_fill + DLY_W'(1);

  // Read tap: (wr_ptr - dly) mod DEPTH, biased by DEPTH
  // so the subtraction never goes negative.
  assign w_sum = XW'(r_wr_ptr) + XW'(DEPTH) - XW'(r_dly);
  assign w_ra  = (w_sum >= XW'(DEPTH)) ?
                 AW'(w_sum - XW'(DEPTH)) : AW'(w_sum);

  // Checked before this edge's fill increment.
  assign w_primed = (r_fill >= r_dly);

  // Storage stays unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en && !clr && !rst)
      r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_dly    <= DLY_W'(1);
      r_dout   <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_dly    <= w_dly_c;
      r_dout   <= '0;
    end else if (w_chg) begin
      // New delay restarts priming; dout holds.
      r_dly  <= w_dly_c;
      r_fill <= '0;
      if (en)
        r_wr_ptr <= w_ptr_nxt;
    end else if (en) begin
      // Old contents are read even when ra == wr_ptr.
      r_dout   <= r_mem[w_ra];
      r_wr_ptr <= w_ptr_nxt;
      r_fill   <= w_fill_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= PRIME;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      clr:   w_state_nxt = PRIME;
      w_chg: w_state_nxt = PRIME;
      default: begin
        if (en && r_state == PRIME && w_primed)
          w_state_nxt = RUN;
      end
    endcase
  end

  assign dout       = r_dout;
  assign dout_valid = (r_state == RUN);

`ifdef DLY_LINE_FILL_EN
  assign fill_lvl = r_fill;
  assign dly_eff  = r_dly;
`endif

endmodule

// File: tb/tb_dly_line_tap.sv
// tb_dly_line_tap: directed bench for dly_line_tap at DEPTH=8.
// Ramp stimulus with hand-computed delayed outputs and valid timing.
module tb_dly_line_tap;

  localparam int SW = 16;
  localparam int DP = 8;
  localparam int DW = $clog2(DP+1);

  logic          clk;
  logic          rst;
  logic          clr;
  logic          en;
  logic [DW-1:0] dly;
  logic [SW-1:0] din;
  logic [SW-1:0] dout;
  logic          dout_valid;
`ifdef DLY_LINE_FILL_EN
  logic [DW-1:0] fill_lvl;
  logic [DW-1:0] dly_eff;
`endif

  int total;
  int bad;

  dly_line_tap #(
    .SIG_WIDTH(SW),
    .DEPTH(DP)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en(en),
    .dly(dly),
    .din(din),
    .dout(dout),
    .dout_valid(dout_valid)
`ifdef DLY_LINE_FILL_EN
    ,
    .fill_lvl(fill_lvl),
    .dly_eff(dly_eff)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr(input int d);
    dly = DW'(d);
    clr = 1'b1;
    en  = 1'b0;
    tick();
    clr = 1'b0;
    chk("clr_dout", 32'(dout), 0);
    chk("clr_vld", 32'(dout_valid), 0);
  endtask

  // Ramp 1..n from a fresh prime; de is the clamped delay.
  task automatic run_ramp(input int n, input int de,
                          input string tag);
    for (int k = 1; k <= n; k++) begin
      en  = 1'b1;
      din = SW'(k);
      tick();
      chk({tag, "_vld"}, 32'(dout_valid), 32'(k > de));
      if (k > de)
        chk({tag, "_dout"}, 32'(dout), 32'(k - de));
`ifdef DLY_LINE_FILL_EN
      chk({tag, "_fill"}, 32'(fill_lvl),
          32'((k < DP) ? k : DP));
      chk({tag, "_deff"}, 32'(dly_eff), 32'(de));
`endif
    end
    en = 1'b0;
  endtask

  // Delay 3 -> 5 at sample 10, with gap idle cycles per strobe.
  task automatic run_switch(input int gap, input string tag);
    int ev;
    int ed;
    do_clr(3);
    for (int k = 1; k <= 18; k++) begin
      en  = 1'b1;
      din = SW'(k);
      if (k == 10)
        dly = DW'(5);
      tick();
      en = 1'b0;
      if (k <= 9) begin
        ev = (k > 3) ? 1 : 0;
        ed = k - 3;
      end else if (k == 10) begin
        ev = 0;
        ed = 6;
      end else if (k <= 15) begin
        ev = 0;
        ed = -1;
      end else begin
        ev = 1;
        ed = k - 5;
      end
      chk({tag, "_vld"}, 32'(dout_valid), 32'(ev));
      if (ed >= 0 && (ev == 1 || k == 10))
        chk({tag, "_dout"}, 32'(dout), 32'(ed));
      for (int g = 0; g < gap; g++) begin
        din = 16'hDEAD;
        tick();
        chk({tag, "_hvld"}, 32'(dout_valid), 32'(ev));
        if (ed >= 0 && (ev == 1 || k == 10))
          chk({tag, "_hdout"}, 32'(dout), 32'(ed));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clr   = 1'b0;
    en    = 1'b0;
    dly   = DW'(3);
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_vld", 32'(dout_valid), 0);
`ifdef DLY_LINE_FILL_EN
    chk("rst_fill", 32'(fill_lvl), 0);
    chk("rst_deff", 32'(dly_eff), 1);
`endif
    rst = 1'b0;

    do_clr(3);
    run_ramp(10, 3, "d3");

    do_clr(8);
    run_ramp(20, 8, "d8");

    do_clr(0);
    run_ramp(6, 1, "d0");

    do_clr(15);
    run_ramp(12, 8, "d15");

    run_switch(0, "sw");
    run_switch(2, "swsp");

    // clr with en and a delay change in the same cycle.
    clr = 1'b1;
    en  = 1'b1;
    din = SW'(99);
    dly = DW'(2);
    tick();
    clr = 1'b0;
    en  = 1'b0;
    chk("cc_dout", 32'(dout), 0);
    chk("cc_vld", 32'(dout_valid), 0);
`ifdef DLY_LINE_FILL_EN
    chk("cc_fill", 32'(fill_lvl), 0);
    chk("cc_deff", 32'(dly_eff), 2);
`endif
    run_ramp(6, 2, "cc2");

    // Async reset between clock edges.
    rst = 1'b1;
    #2;
    chk("arst_dout", 32'(dout), 0);
    chk("arst_vld", 32'(dout_valid), 0);
    tick();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
